apb_master_bridge: RTL and testbench



---
 rtl/apb_master_bridge.sv | 148 ++++++++++++++
 tb/tb_apb_master_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid data port to APB4 master bridge, one transfer at a time.
// Optional ACCESS-phase timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
  output logic                      data_err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic [3:0]                pstrb_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i,
  output logic [1:0]                dbg_state_o
);

  if (APB_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("apb_master_bridge: APB_DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   gnt, load, done, expire;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;

  // Counts ACCESS cycles already spent without pready; expiry fires in the
  // TIMEOUT_CYCLES-th ACCESS cycle unless pready arrives in that same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready_i) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Handshake: a request is accepted in any cycle where data_req_i and
  // data_gnt_o are both high; gnt is only offered in IDLE, so at most one
  // transfer is outstanding and data_rvalid_o answers it exactly once.
  always_comb begin
    state_d = state_q;
    gnt     = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        gnt = data_req_i;
        if (data_req_i) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end
`ifdef APB_BRIDGE_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_gnt_o  = gnt & rst_ni;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      paddr_o       <= '0;
      pwdata_o      <= '0;
      pwrite_o      <= 1'b0;
      pstrb_o       <= 4'b0000;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      data_rvalid_o <= 1'b0;
      data_err_o    <= 1'b0;
      if (load) begin
        paddr_o   <= data_addr_i;
        pwdata_o  <= data_wdata_i;
        pwrite_o  <= data_we_i;
        pstrb_o   <= data_we_i ? data_be_i : 4'b0000;
        psel_o    <= 1'b1;
        penable_o <= 1'b0;
      end
      if (state_q == SETUP) begin
        penable_o <= 1'b1;
      end
      if (done) begin
        psel_o        <= 1'b0;
        penable_o     <= 1'b0;
        data_rvalid_o <= 1'b1;
        data_err_o    <= pslverr_i;
        data_rdata_o  <= pwrite_o ? '0 : prdata_i;
      end
      if (expire) begin
        psel_o        <= 1'b0;
        penable_o     <= 1'b0;
        data_rvalid_o <= 1'b1;
        data_err_o    <= 1'b1;
        data_rdata_o  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: bench-side APB responder, response
// scoreboard and per-cycle protocol/latency checks.
module tb_apb_master_bridge;

  logic        clk;
  logic        rst_n;
  logic        data_req;
  logic        data_gnt;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic [3:0]  pstrb;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [32:0] exp_q[$];

  apb_master_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .data_req_i(data_req),
    .data_gnt_o(data_gnt),
    .data_addr_i(data_addr),
    .data_we_i(data_we),
    .data_be_i(data_be),
    .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata),
    .data_err_o(data_err),
    .paddr_o(paddr),
    .pwdata_o(pwdata),
    .pwrite_o(pwrite),
    .pstrb_o(pstrb),
    .psel_o(psel),
    .penable_o(penable),
    .prdata_i(prdata),
    .pready_i(pready),
    .pslverr_i(pslverr),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    data_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_rvalid", data_rvalid, 1'b0);
      check("idle_psel", {psel, penable}, 2'b00);
    end
  endtask

  // One full transfer, entered and left at a negedge; the rvalid cycle is the
  // last one observed so a following call can be granted in that same cycle.
  task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata, input int waits, input logic serr,
                      input logic [31:0] prd, input logic hold);
    logic [3:0]  exp_strb;
    logic [32:0] exp;
    int          lat;
    exp_strb   = we ? be : 4'b0000;
    data_req   = 1'b1;
    data_addr  = addr;
    data_we    = we;
    data_be    = be;
    data_wdata = wdata;
    #1;
    check("gnt", data_gnt, 1'b1);
    lat = 0;
    @(posedge clk);
    @(negedge clk);
    lat++;
    if (hold) begin
      data_addr  = $urandom;
      data_we    = 1'($urandom_range(0, 1));
      data_be    = 4'($urandom_range(0, 15));
      data_wdata = $urandom;
    end else begin
      data_req = 1'b0;
    end
    #1;
    check("setup_psel_penable", {psel, penable}, 2'b10);
    check("setup_gnt", data_gnt, 1'b0);
    check("setup_rvalid", data_rvalid, 1'b0);
    check("setup_paddr", paddr, addr);
    check("setup_pwrite", pwrite, we);
    check("setup_pstrb", pstrb, exp_strb);
    if (we) check("setup_pwdata", pwdata, wdata);
    for (int w = 0; w <= waits; w++) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      check("access_psel_penable", {psel, penable}, 2'b11);
      check("access_paddr", paddr, addr);
      check("access_pwrite", pwrite, we);
      check("access_pstrb", pstrb, exp_strb);
      if (we) check("access_pwdata", pwdata, wdata);
      check("access_rvalid", data_rvalid, 1'b0);
      check("access_gnt", data_gnt, 1'b0);
      if (w == waits) begin
        pready  = 1'b1;
        prdata  = prd;
        pslverr = serr;
        exp_q.push_back({serr, we ? 32'h0 : prd});
      end else begin
        pready  = 1'b0;
        prdata  = $urandom;
        pslverr = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    @(negedge clk);
    lat++;
    pready  = 1'b0;
    prdata  = $urandom;
    pslverr = 1'($urandom_range(0, 1));
    check("resp_rvalid", data_rvalid, 1'b1);
    check("resp_psel_penable", {psel, penable}, 2'b00);
    check("resp_latency", lat, 3 + waits);
    check("sb_nonempty", exp_q.size() > 0, 1'b1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
    check("resp_err_rdata", {data_err, data_rdata}, exp);
  endtask

  task automatic start_stall(input logic [31:0] addr);
    data_req  = 1'b1;
    data_addr = addr;
    data_we   = 1'b0;
    data_be   = 4'hF;
    pready    = 1'b0;
    #1;
    check("stall_gnt", data_gnt, 1'b1);
    @(posedge clk);
    @(negedge clk);
    data_req = 1'b0;
    check("stall_setup", {psel, penable}, 2'b10);
  endtask

  initial begin
    int          n;
    logic [32:0] resp;
    logic [31:0] a;
    logic        w;
    int          waits;
    logic        hold;

    rst_n      = 1'b0;
    data_req   = 1'b1;
    data_addr  = $urandom;
    data_we    = 1'b1;
    data_be    = 4'hF;
    data_wdata = $urandom;
    prdata     = $urandom;
    pready     = 1'b1;
    pslverr    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_paddr", paddr, 32'h0);
    check("rst_pwdata", pwdata, 32'h0);
    check("rst_rdata", data_rdata, 32'h0);
    check("rst_ctrl", {pstrb, pwrite, psel, penable, data_rvalid, data_err, data_gnt}, 10'h0);
    data_req = 1'b0;
    pready   = 1'b0;
    pslverr  = 1'b0;
    rst_n    = 1'b1;
    idle(2);

    // directed transfers
    xfer(32'h1A10_0000, 1'b0, 4'hF, $urandom, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    xfer(32'h1A10_1008, 1'b1, 4'b0001, 32'h0000_00A5, 3, 1'b0, $urandom, 1'b0);
    idle(1);
    xfer(32'h1A10_2000, 1'b0, 4'hF, $urandom, 1, 1'b1, $urandom, 1'b0);
    xfer(32'h1A10_2004, 1'b0, 4'hF, $urandom, 0, 1'b0, 32'h1234_5678, 1'b0);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      xfer(32'h1A10_3000 + 32'(i * 4), 1'b0, 4'hF, $urandom, 0, 1'b0, $urandom, 1'b1);
    end
    idle(2);
    xfer(32'h1A10_4001, 1'b0, 4'hF, $urandom, 7, 1'b0, 32'hCAFE_F00D, 1'b0);
    idle(1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      a     = $urandom;
      w     = 1'($urandom_range(0, 1));
      waits = $urandom_range(0, 4);
      hold  = 1'($urandom_range(0, 1));
      xfer(a, w, 4'($urandom_range(0, 15)), $urandom, waits,
           1'($urandom_range(0, 3) == 0), $urandom, hold);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);

`ifdef APB_BRIDGE_TIMEOUT_EN
    start_stall(32'h1A10_5000);
    exp_q.push_back({1'b1, 32'h0});
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
      if (psel && penable) n++;
      else break;
    end
    check("timeout_access_cycles", n, 8);
    check("timeout_rvalid", data_rvalid, 1'b1);
    resp = exp_q.pop_front();
    check("timeout_resp", {data_err, data_rdata}, resp);
    pslverr = 1'b0;
    idle(1);
    start_stall(32'h1A10_6000);
    repeat (3) @(negedge clk);
    check("stall_in_access", {psel, penable}, 2'b11);
`else
    start_stall(32'h1A10_5000);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      @(negedge clk);
      prdata  = $urandom;
      pslverr = 1'($urandom_range(0, 1));
      if (psel && penable && !data_rvalid) n++;
    end
    check("no_timeout_hold", n, 1000);
`endif

    // asynchronous reset while in ACCESS
    #2;
    rst_n    = 1'b0;
    data_req = 1'b1;
    #1;
    check("rst_async_ctrl", {psel, penable, data_rvalid, data_err, data_gnt}, 5'b0);
    repeat (2) @(negedge clk);
    check("rst_hold_ctrl", {psel, penable, data_rvalid, data_gnt}, 4'b0);
    data_req = 1'b0;
    pslverr  = 1'b0;
    rst_n    = 1'b1;
    idle(4);
    xfer(32'h1A10_7000, 1'b1, 4'b1100, 32'h5A5A_A5A5, 2, 1'b0, $urandom, 1'b0);
    idle(2);
    check("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
